// File: rtl/apb_spi_slave.sv
// SPI mode-0 target with an APB3 register front end. SPI pins are synchronised into
// pclk_i; frames of LEN+1 bits are received MSB-first while TXDATA is shifted out on sdo_o.
module apb_spi_slave #(
    parameter int DW       = 32,
    parameter int SYNC_STG = 2
) (
    input  logic        pclk_i,
    input  logic        prst_n_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    input  logic        sclk_i,
    input  logic        cs_n_i,
    input  logic        sdi_i,
    output logic        sdo_o,
    output logic        eot_o
);
    localparam int LW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT} state_t;

    state_t                state;
    logic [SYNC_STG-1:0]   sclk_sync, cs_sync, sdi_sync;
    logic                  sclk_d, cs_d;
    logic                  en, busy, rx_valid, ovr;
    logic [LW-1:0]         len, bit_cnt;
    logic [DW-1:0]         txdata, rxdata, tx_sh, rx_sh, tx_next;
    logic                  sclk_s, cs_s, sdi_s;
    logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                  rd_acc, wr_acc, rd_rx;
    logic [2:0]            reg_sel;
    logic                  unused_addr;

    function automatic logic [DW-1:0] len_mask(input logic [LW-1:0] l);
        len_mask = '0;
        for (int i = 0; i < DW; i++)
            if (i <= int'(l)) len_mask[i] = 1'b1;
    endfunction

    assign unused_addr = &{1'b0, paddr_i[31:5], paddr_i[1:0]};
    assign pready_o    = 1'b1;
    assign reg_sel     = paddr_i[4:2];
    assign rd_acc      = psel_i & penable_i & ~pwrite_i;
    assign wr_acc      = psel_i & penable_i & pwrite_i;
    assign rd_rx       = rd_acc & (reg_sel == 3'd3);

    assign sclk_s    = sclk_sync[SYNC_STG-1];
    assign cs_s      = cs_sync[SYNC_STG-1];
    assign sdi_s     = sdi_sync[SYNC_STG-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign tx_next   = tx_sh << 1;

    always_comb begin
        prdata_o = '0;
        if (rd_acc) begin
            case (reg_sel)
                3'd0:    prdata_o = {31'd0, en};
                3'd1:    prdata_o = 32'(len);
                3'd2:    prdata_o = 32'(txdata);
                3'd3:    prdata_o = 32'(rxdata);
                3'd4:    prdata_o = {29'd0, ovr, rx_valid, busy};
                default: prdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge pclk_i or posedge prst_n_i) begin
        if (prst_n_i) begin
            state     <= IDLE;
            sclk_sync <= '0;
            cs_sync   <= '0;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            rx_valid  <= 1'b0;
            ovr       <= 1'b0;
            len       <= LW'(DW - 1);
            bit_cnt   <= '0;
            txdata    <= '0;
            rxdata    <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            sdo_o     <= 1'b0;
            eot_o     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STG-2:0], cs_n_i};
            sdi_sync  <= {sdi_sync[SYNC_STG-2:0], sdi_i};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            eot_o     <= 1'b0;

            if (wr_acc) begin
                case (reg_sel)
                    3'd0:    en     <= pwdata_i[0];
                    3'd1:    len    <= pwdata_i[LW-1:0];
                    3'd2:    txdata <= pwdata_i[DW-1:0];
                    3'd5:    if (pwdata_i[2]) ovr <= 1'b0;
                    default: ;
                endcase
            end
            if (rd_rx) rx_valid <= 1'b0;

            // Frame FSM: later assignments here take priority over the register writes above
            case (state)
                IDLE: begin
                    if (cs_fall && en) begin
                        tx_sh   <= txdata;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        sdo_o   <= txdata[len];
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        sdo_o   <= 1'b0;
                        state   <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sh   <= {rx_sh[DW-2:0], sdi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == len) begin
                            sdo_o <= 1'b0;
                            state <= DONE;
                        end
                    end else if (sclk_fall) begin
                        tx_sh <= tx_next;
                        sdo_o <= tx_next[len];
                    end
                end
                DONE: begin
                    rxdata   <= rx_sh & len_mask(len);
                    eot_o    <= 1'b1;
                    if (rx_valid && !rd_rx) ovr <= 1'b1;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: begin
                    sdo_o <= 1'b0;
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_spi_slave.sv
// Bench for apb_spi_slave: an SPI mode-0 master model plus APB accesses, with
// table-driven frames, a scoreboard of expected results and hand-written corner cases.
module tb_apb_spi_slave;
    logic        pclk = 1'b0;
    logic        prst_n = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, prdata;
    logic        pready;
    logic        sclk = 1'b0, cs_n = 1'b1, sdi = 1'b0;
    logic        sdo, eot;

    int checks = 0;
    int errors = 0;
    int eot_cnt = 0;

    apb_spi_slave #(.DW(32), .SYNC_STG(2)) dut (
        .pclk_i(pclk), .prst_n_i(prst_n), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .sclk_i(sclk), .cs_n_i(cs_n), .sdi_i(sdi),
        .sdo_o(sdo), .eot_o(eot)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (eot) eot_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        en;
        logic [4:0]  len;
        logic [31:0] tx;
        logic [31:0] mosi;
        int          nbits;
        logic [31:0] exp_miso;
        logic [31:0] exp_rx;
        int          exp_eot;
        logic [31:0] exp_status;
    } vec_t;

    typedef struct {
        logic [31:0] miso;
        logic [31:0] rx;
        int          eot;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1 d = prdata;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // Mode-0 master: sdi set while sclk low, sdo sampled at the sclk rise.
    // nclk < nbits stops early and raises cs_n (abort).
    task automatic spi_frame(input int nbits, input logic [31:0] mosi, input int nclk,
                             output logic [31:0] miso);
        miso = '0;
        @(negedge pclk);
        cs_n = 1'b0;
        repeat (6) @(negedge pclk);
        for (int b = 0; b < nclk; b++) begin
            sdi = mosi[nbits-1-b];
            repeat (4) @(negedge pclk);
            sclk = 1'b1;
            miso[nbits-1-b] = sdo;
            repeat (4) @(negedge pclk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge pclk);
        cs_n = 1'b1;
        sdi  = 1'b0;
        repeat (6) @(negedge pclk);
    endtask

    vec_t        vecs[5];
    logic [31:0] rd, miso;
    exp_t        e;
    int          e0;

    initial begin
        vecs[0] = '{1'b1, 5'd15, 32'h0000A5C3, 32'h00001234, 16, 32'h0000A5C3, 32'h00001234, 1, 32'h2};
        vecs[1] = '{1'b1, 5'd0,  32'h00000001, 32'h00000001, 1,  32'h00000001, 32'h00000001, 1, 32'h2};
        vecs[2] = '{1'b1, 5'd31, 32'h12345678, 32'hDEADBEEF, 32, 32'h12345678, 32'hDEADBEEF, 1, 32'h2};
        vecs[3] = '{1'b0, 5'd15, 32'h0000FFFF, 32'h00005555, 16, 32'h00000000, 32'hDEADBEEF, 0, 32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h000001A5, 32'h0000003C, 8,  32'h000000A5, 32'h0000003C, 1, 32'h2};

        repeat (5) @(negedge pclk);
        #1;
        check("reset_sdo", {31'd0, sdo}, 32'h0);
        check("reset_eot", {31'd0, eot}, 32'h0);
        prst_n = 1'b0;
        @(negedge pclk);
        check("reset_prdata_idle", prdata, 32'h0);
        check("reset_pready", {31'd0, pready}, 32'h1);
        apb_read(32'h10, rd); check("reset_status", rd, 32'h0);
        apb_read(32'h04, rd); check("reset_len", rd, 32'h1F);
        apb_read(32'h0C, rd); check("reset_rxdata", rd, 32'h0);

        foreach (vecs[i]) begin
            apb_write(32'h00, {31'd0, vecs[i].en});
            apb_write(32'h04, {27'd0, vecs[i].len});
            apb_write(32'h08, vecs[i].tx);
            sb.push_back('{vecs[i].exp_miso, vecs[i].exp_rx, vecs[i].exp_eot});
            e0 = eot_cnt;
            spi_frame(vecs[i].nbits, vecs[i].mosi, vecs[i].nbits, miso);
            e = sb.pop_front();
            check($sformatf("v%0d_miso", i), miso, e.miso);
            check($sformatf("v%0d_eot", i), 32'(eot_cnt - e0), 32'(e.eot));
            apb_read(32'h10, rd); check($sformatf("v%0d_status", i), rd, vecs[i].exp_status);
            apb_read(32'h0C, rd); check($sformatf("v%0d_rxdata", i), rd, e.rx);
            apb_read(32'h10, rd); check($sformatf("v%0d_status_after_rd", i), rd, 32'h0);
        end

        // Overrun: two frames without an RXDATA read in between
        apb_write(32'h00, 32'h1);
        apb_write(32'h04, 32'd15);
        apb_write(32'h08, 32'h0000A5C3);
        e0 = eot_cnt;
        spi_frame(16, 32'h0F0F, 16, miso);
        apb_read(32'h10, rd); check("ovr_status1", rd, 32'h2);
        spi_frame(16, 32'h1111, 16, miso);
        check("ovr_eot", 32'(eot_cnt - e0), 32'd2);
        apb_read(32'h10, rd); check("ovr_status2", rd, 32'h6);
        apb_read(32'h0C, rd); check("ovr_rxdata", rd, 32'h1111);
        apb_read(32'h10, rd); check("ovr_status3", rd, 32'h4);
        apb_write(32'h14, 32'h4);
        apb_read(32'h10, rd); check("ovr_cleared", rd, 32'h0);

        // Abort after 7 clocks, then a clean frame
        e0 = eot_cnt;
        spi_frame(16, 32'hFFFF, 7, miso);
        check("abort_eot", 32'(eot_cnt - e0), 32'd0);
        apb_read(32'h10, rd); check("abort_status", rd, 32'h0);
        apb_read(32'h0C, rd); check("abort_rxdata", rd, 32'h1111);
        sb.push_back('{32'h0000A5C3, 32'h0000BEEF, 1});
        e0 = eot_cnt;
        spi_frame(16, 32'hBEEF, 16, miso);
        e = sb.pop_front();
        check("post_abort_miso", miso, e.miso);
        check("post_abort_eot", 32'(eot_cnt - e0), 32'(e.eot));
        apb_read(32'h0C, rd); check("post_abort_rxdata", rd, e.rx);

        // Reset in the middle of a frame
        @(negedge pclk);
        cs_n = 1'b0;
        repeat (6) @(negedge pclk);
        for (int b = 0; b < 3; b++) begin
            sdi = 1'b1;
            repeat (4) @(negedge pclk);
            sclk = 1'b1;
            repeat (4) @(negedge pclk);
            sclk = 1'b0;
        end
        prst_n = 1'b1;
        #1;
        check("midrst_sdo", {31'd0, sdo}, 32'h0);
        check("midrst_eot", {31'd0, eot}, 32'h0);
        check("midrst_prdata", prdata, 32'h0);
        repeat (3) @(negedge pclk);
        cs_n = 1'b1;
        sdi  = 1'b0;
        repeat (3) @(negedge pclk);
        prst_n = 1'b0;
        repeat (4) @(negedge pclk);
        apb_read(32'h10, rd); check("midrst_status", rd, 32'h0);
        apb_read(32'h04, rd); check("midrst_len", rd, 32'h1F);
        apb_read(32'h00, rd); check("midrst_ctrl", rd, 32'h0);
        apb_read(32'h0C, rd); check("midrst_rxdata", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
